ucode_pipe: RTL and testbench
=============================

UCODE_PIPE -- requirements
Module: ucode_pipe

Interface
REQ-001 Parameter: AW, default 8, control-store address width (store depth 2^AW).
REQ-002 Parameter: RESET_WORD, default 24'h0_8_0000, microword loaded into the pipeline register on reset (I=0, CCEN_BAR=1, all other fields 0).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Y  input  12  microaddress from the sequencer.
REQ-006 PL_BAR  input  1  sequencer source strobe; 1 = D driven by map or vector, 0 = D driven by the pipeline branch field.
REQ-007 MAP_BAR  input  1  1 = map source selected.
REQ-008 VECT_BAR  input  1  1 = vector source selected.
REQ-009 map_in  input  12  opcode-map address.
REQ-010 vect_in  input  12  interrupt-vector address.
REQ-011 cond_in  input  8  raw status flags.
REQ-012 status_ld  input  1  capture cond_in into the status register.
REQ-013 hold  input  1  freeze the pipeline register.
REQ-014 wr_en  input  1  control-store write strobe.
REQ-015 wr_addr  input  AW  control-store write address.
REQ-016 wr_data  input  24  control-store write data.
REQ-017 I  output  4  sequencer instruction, pipe[23:20].
REQ-018 CCEN_BAR  output  1  condition-enable, pipe[19].
REQ-019 CC_BAR  output  1  condition code to the sequencer.
REQ-020 D  output  12  sequencer direct input.
REQ-021 ctl_out  output  4  datapath control field, pipe[14:12].
REQ-022 addr_err  output  1  sticky out-of-range fetch flag.

Function
REQ-023 Microword layout: [23:20] I, [19] CCEN_BAR, [18:16] cond select, [15] cond polarity, [14:12] ctl_out, [11:0] branch field; ctl_out[3] is constant 0.
REQ-024 Control store: 2^AW x 24 bits, not reset, contents undefined until written.
REQ-025 Write: when wr_en=1, store[wr_addr] <= wr_data at the clock edge.
REQ-026 Fetch: when hold=0 and reset=0, pipe <= store[Y[AW-1:0]] at each clock edge; one-cycle latency from Y to I/CCEN_BAR/D/ctl_out.
REQ-027 Read-during-write to the same address in the same cycle returns the old contents to pipe; the new data is visible on the next fetch.
REQ-028 hold=1: pipe retains its value; writes and status loads proceed normally.
REQ-029 Status register: when status_ld=1, status <= cond_in at the clock edge.
REQ-030 CC_BAR combinational: ~(status[pipe[18:16]] ^ pipe[15]); polarity 1 inverts the selected flag.
REQ-031 D combinational: MAP_BAR=1 -> map_in; else VECT_BAR=1 -> vect_in; else PL_BAR=0 -> pipe[11:0]; else (PL_BAR=1 with neither MAP_BAR nor VECT_BAR) -> 12'h000.
REQ-032 MAP_BAR takes priority over VECT_BAR when both are 1.
REQ-033 addr_err set when a fetch occurs (hold=0) with Y[11:AW] != 0; the fetch still uses Y[AW-1:0] (wrap). Once set, addr_err stays 1 until reset.
REQ-034 No fetch, status load or addr_err update occurs while reset=1.

Reset
REQ-035 reset=1 at a clock edge: pipe <= RESET_WORD, status <= 8'h00, addr_err <= 0; a store write on the same edge still occurs.
REQ-036 After reset with default RESET_WORD: I=4'h0, CCEN_BAR=1, ctl_out=4'h0, CC_BAR=1 (status[0]=0, polarity 0), D=12'h000 when PL_BAR=0.
REQ-037 Reset asserted mid-operation overrides hold and pending fetch on the same edge.

Verification
REQ-038 Write store[5]=24'h3_0_0_123, then Y=12'h005 -> next cycle I=4'h3, CCEN_BAR=0, D=12'h123 with PL_BAR=0.
REQ-039 status_ld with cond_in=8'h04, pipe sel=2 -> polarity 0 gives CC_BAR=0; polarity 1 gives CC_BAR=1.
REQ-040 Same edge: wr_en to addr 7 (new value) and Y=7 -> pipe takes old value; the following fetch of 7 returns the new value.
REQ-041 MAP_BAR=1, VECT_BAR=1, map_in=12'hABC, vect_in=12'h111 -> D=12'hABC; MAP_BAR=0, VECT_BAR=1 -> D=12'h111.
REQ-042 hold=1 for 3 cycles while Y changes -> I/D unchanged; Y=12'h105 with AW=8 -> addr_err=1, pipe=store[5], and addr_err stays 1 until reset.
REQ-043 reset asserted with hold=1 and a non-zero pipe -> next cycle I=0, CCEN_BAR=1, addr_err=0, status=8'h00.

Source files
------------

// File: rtl/ucode_pipe.sv
// Microprogram control store with pipeline register, status/condition select,
// and sequencer D-input source mux.
module ucode_pipe #(
   parameter int          AW         = 8,
   parameter logic [23:0] RESET_WORD = 24'h0_8_0000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [11:0]   Y,
   input  logic          PL_BAR,
   input  logic          MAP_BAR,
   input  logic          VECT_BAR,
   input  logic [11:0]   map_in,
   input  logic [11:0]   vect_in,
   input  logic [7:0]    cond_in,
   input  logic          status_ld,
   input  logic          hold,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [23:0]   wr_data,
   output logic [3:0]    I,
   output logic          CCEN_BAR,
   output logic          CC_BAR,
   output logic [11:0]   D,
   output logic [3:0]    ctl_out,
   output logic          addr_err
);

   localparam int DEPTH = 1 << AW;

   typedef struct packed {
      logic [3:0]  instr;
      logic        ccen_bar;
      logic [2:0]  cond_sel;
      logic        cond_pol;
      logic [2:0]  ctl;
      logic [11:0] branch;
   } uword_t;

   logic [23:0] store [DEPTH];
   uword_t      pipe;
   logic [7:0]  status;
   logic        y_out_of_range;

   assign y_out_of_range = (Y >> AW) != 12'h000;

   // NOTE: the control store has no reset; clearing a RAM array forbids block-RAM mapping.
   always_ff @(posedge clk) begin
      if (wr_en)
         store[wr_addr] <= wr_data;
   end

   // NOTE: non-blocking state updates make a same-edge write invisible to this read,
   // which yields the required old-data read-during-write behaviour.
   always_ff @(posedge clk) begin
      if (reset) begin
         pipe     <= uword_t'(RESET_WORD);
         status   <= 8'h00;
         addr_err <= 1'b0;
      end else begin
         if (!hold) begin
            pipe <= uword_t'(store[Y[AW-1:0]]);
            if (y_out_of_range)
               addr_err <= 1'b1;
         end
         if (status_ld)
            status <= cond_in;
      end
   end

   assign I        = pipe.instr;
   assign CCEN_BAR = pipe.ccen_bar;
   assign ctl_out  = {1'b0, pipe.ctl};
   assign CC_BAR   = ~(status[pipe.cond_sel] ^ pipe.cond_pol);

   // NOTE: the default assignment first keeps this mux from inferring a latch.
   always_comb begin
      D = 12'h000;
      if (MAP_BAR)
         D = map_in;
      else if (VECT_BAR)
         D = vect_in;
      else if (!PL_BAR)
         D = pipe.branch;
   end

endmodule

// File: tb/tb_ucode_pipe.sv
// Self-checking bench for ucode_pipe: directed cases plus randomized traffic
// compared against a behavioural model of store, pipeline and status.
module tb_ucode_pipe;

   localparam int          AW    = 8;
   localparam int          DEPTH = 256;
   localparam logic [23:0] RST_W = 24'h0_8_0000;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [11:0]   Y = '0;
   logic          PL_BAR = 1'b0, MAP_BAR = 1'b0, VECT_BAR = 1'b0;
   logic [11:0]   map_in = '0, vect_in = '0;
   logic [7:0]    cond_in = '0;
   logic          status_ld = 1'b0, hold = 1'b0, wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [23:0]   wr_data = '0;
   logic [3:0]    I, ctl_out;
   logic          CCEN_BAR, CC_BAR, addr_err;
   logic [11:0]   D;

   int errors = 0;
   int checks = 0;

   // behavioural model state
   logic [23:0] m_store [DEPTH];
   logic [23:0] m_pipe;
   logic [7:0]  m_status;
   logic        m_err;

   ucode_pipe #(.AW(AW), .RESET_WORD(RST_W)) dut (
      .clk(clk), .reset(reset), .Y(Y), .PL_BAR(PL_BAR), .MAP_BAR(MAP_BAR),
      .VECT_BAR(VECT_BAR), .map_in(map_in), .vect_in(vect_in), .cond_in(cond_in),
      .status_ld(status_ld), .hold(hold), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .I(I), .CCEN_BAR(CCEN_BAR), .CC_BAR(CC_BAR), .D(D),
      .ctl_out(ctl_out), .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock edge; the model sees the same pre-edge inputs as the DUT.
   task automatic step();
      @(posedge clk);
      if (reset) begin
         m_pipe   = RST_W;
         m_status = 8'h00;
         m_err    = 1'b0;
      end else begin
         if (!hold) begin
            m_pipe = m_store[int'(Y) % DEPTH];
            if (int'(Y) >= DEPTH) m_err = 1'b1;
         end
         if (status_ld) m_status = cond_in;
      end
      if (wr_en) m_store[int'(wr_addr)] = wr_data;
      #1;
   endtask

   function automatic logic [11:0] exp_d();
      if (MAP_BAR)       return map_in;
      else if (VECT_BAR) return vect_in;
      else if (!PL_BAR)  return m_pipe % 4096;
      else               return 12'h000;
   endfunction

   function automatic logic exp_cc();
      int sel, pol, flag;
      sel  = (m_pipe / 65536) % 8;
      pol  = (m_pipe / 32768) % 2;
      flag = (m_status >> sel) % 2;
      return (flag == pol) ? 1'b1 : 1'b0;
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".I"},        24'(I),        (m_pipe / 1048576) % 16);
      check({tag, ".CCEN_BAR"}, 24'(CCEN_BAR), (m_pipe / 524288) % 2);
      check({tag, ".ctl_out"},  24'(ctl_out),  (m_pipe / 4096) % 8);
      check({tag, ".D"},        24'(D),        24'(exp_d()));
      check({tag, ".CC_BAR"},   24'(CC_BAR),   24'(exp_cc()));
      check({tag, ".addr_err"}, 24'(addr_err), 24'(m_err));
   endtask

   task automatic write_word(input logic [AW-1:0] a, input logic [23:0] w);
      wr_en = 1'b1; wr_addr = a; wr_data = w;
      step();
      wr_en = 1'b0;
   endtask

   initial begin
      m_pipe = '0; m_status = '0; m_err = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_store[i] = 'x;

      // reset, then fill the store under hold so the reset word stays visible
      step();
      reset = 1'b0;
      hold  = 1'b1;
      for (int i = 0; i < DEPTH; i++) write_word(AW'(i), 24'($urandom));
      check("rst.I", 24'(I), 24'h0);
      check("rst.CCEN_BAR", 24'(CCEN_BAR), 24'h1);
      check("rst.ctl_out", 24'(ctl_out), 24'h0);
      check("rst.CC_BAR", 24'(CC_BAR), 24'h1);
      check("rst.D", 24'(D), 24'h000);
      check("rst.addr_err", 24'(addr_err), 24'h0);

      // basic fetch
      write_word(8'd5, 24'h3_0_0123);
      hold = 1'b0; Y = 12'h005;
      step();
      check("fetch.I", 24'(I), 24'h3);
      check("fetch.CCEN_BAR", 24'(CCEN_BAR), 24'h0);
      check("fetch.D", 24'(D), 24'h123);
      check_all("fetch");

      // condition select and polarity
      hold = 1'b1;
      write_word(8'd9, 24'h02_0000);
      write_word(8'd10, 24'h02_8000);
      status_ld = 1'b1; cond_in = 8'h04;
      step();
      status_ld = 1'b0; hold = 1'b0; Y = 12'h009;
      step();
      check("cc.pol0", 24'(CC_BAR), 24'h0);
      Y = 12'h00A;
      step();
      check("cc.pol1", 24'(CC_BAR), 24'h1);
      check_all("cc");

      // read-during-write returns old data
      hold = 1'b1;
      write_word(8'd7, 24'h11_1111);
      hold = 1'b0; Y = 12'h007;
      write_word(8'd7, 24'h7E_D321);
      check("rdw.old_I", 24'(I), 24'h1);
      check("rdw.old_D", 24'(D), 24'h111);
      step();
      check("rdw.new_I", 24'(I), 24'h7);
      check("rdw.new_D", 24'(D), 24'h321);
      check("rdw.new_ctl", 24'(ctl_out), 24'h5);
      check_all("rdw");

      // D source priority
      map_in = 12'hABC; vect_in = 12'h111; MAP_BAR = 1'b1; VECT_BAR = 1'b1; #1;
      check("dmux.map", 24'(D), 24'hABC);
      MAP_BAR = 1'b0; #1;
      check("dmux.vect", 24'(D), 24'h111);
      VECT_BAR = 1'b0; PL_BAR = 1'b1; #1;
      check("dmux.zero", 24'(D), 24'h000);
      PL_BAR = 1'b0; #1;
      check("dmux.pipe", 24'(D), 24'h321);

      // hold freezes the pipe while Y moves
      Y = 12'h005;
      step();
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         Y = 12'(9 + i);
         step();
         check("hold.I", 24'(I), 24'h3);
         check("hold.D", 24'(D), 24'h123);
      end
      check("hold.addr_err", 24'(addr_err), 24'h0);

      // out-of-range fetch wraps and sets the sticky flag
      hold = 1'b0; Y = 12'h105;
      step();
      check("oor.addr_err", 24'(addr_err), 24'h1);
      check("oor.I", 24'(I), 24'h3);
      check("oor.D", 24'(D), 24'h123);
      Y = 12'h009;
      for (int i = 0; i < 3; i++) begin
         step();
         check("oor.sticky", 24'(addr_err), 24'h1);
      end

      // reset overrides hold on a non-zero pipe
      status_ld = 1'b1; cond_in = 8'hFF;
      step();
      status_ld = 1'b0;
      hold = 1'b1; reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst2.I", 24'(I), 24'h0);
      check("rst2.CCEN_BAR", 24'(CCEN_BAR), 24'h1);
      check("rst2.addr_err", 24'(addr_err), 24'h0);
      check("rst2.CC_BAR", 24'(CC_BAR), 24'h1);
      check_all("rst2");

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         reset     = ($urandom % 40) == 0;
         hold      = ($urandom % 4) == 0;
         Y         = (($urandom % 16) == 0) ? 12'($urandom) : 12'($urandom % DEPTH);
         PL_BAR    = 1'($urandom);
         MAP_BAR   = ($urandom % 4) == 0;
         VECT_BAR  = ($urandom % 4) == 0;
         map_in    = 12'($urandom);
         vect_in   = 12'($urandom);
         cond_in   = 8'($urandom);
         status_ld = 1'($urandom);
         wr_en     = 1'($urandom);
         wr_addr   = AW'(($urandom % 2) ? Y : 12'($urandom));
         wr_data   = 24'($urandom);
         step();
         check_all("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
